// File: rtl/uart_hex_loader_if.sv
// Bus bundle for uart_hex_loader: received byte stream in, program-memory write port out,
// and the echo byte stream toward uart_tx.
interface uart_hex_loader_if #(
  parameter int ADDR_W = 14
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  mem_we, mem_addr, mem_wdata, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output mem_we, mem_addr, mem_wdata, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_hex_loader.sv
// Parses ASCII hex text from uart_rx into 32-bit program-memory writes and holds the core in
// reset until an idle timeout ends loading. Optional byte echo enabled by `define LOADER_ECHO_EN.
//
// state | meaning
// WAIT  | no word written yet, collecting a data token
// DATA  | at least one word written, collecting a data token
// ADDR  | after '@', collecting an address token
// SKIP  | after a malformed token, discarding up to the next separator
// DONE  | idle timeout reached, parser frozen until reset
module uart_hex_loader #(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic               clk,
  input  logic               resetb,
  uart_hex_loader_if.slave   bus,
  output logic               cpu_hold,
  output logic               load_done,
  output logic [15:0]        word_cnt,
  output logic [7:0]         err_cnt,
  output logic               echo_ovf
);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC);

  localparam logic [2:0] ST_WAIT = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_SKIP = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       acc_q, acc_d;
  logic [3:0]        ndig_q, ndig_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, load_done_q;

  logic       is_hex, is_sep, is_at;
  logic [3:0] nibble;

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nibble = bus.rx_data[3:0];
    end else if ((bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66) ||
                 (bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46)) begin
      is_hex = 1'b1;
      nibble = bus.rx_data[3:0] + 4'd9;
    end
    is_sep = (bus.rx_data == 8'h20) || (bus.rx_data == 8'h09) ||
             (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
    is_at  = (bus.rx_data == 8'h40);
  end

  logic       have_word, wr, err_inc;
  logic [2:0] back_st;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    acc_d       = acc_q;
    ndig_d      = ndig_q;
    word_cnt_d  = word_cnt_q;
    err_cnt_d   = err_cnt_q;
    tmr_d       = tmr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr          = 1'b0;
    err_inc     = 1'b0;
    have_word   = (word_cnt_q != 16'd0);
    back_st     = have_word ? ST_DATA : ST_WAIT;

    if (state_q != ST_DONE) begin
      if (bus.rx_valid) begin
        tmr_d = TMR_LOAD;
        if (is_sep) begin
          acc_d  = 32'd0;
          ndig_d = 4'd0;
          case (state_q)
            ST_WAIT, ST_DATA: begin
              if (ndig_q == 4'd8)      wr = 1'b1;
              else if (ndig_q != 4'd0) err_inc = 1'b1;
            end
            ST_ADDR: begin
              if (ndig_q != 4'd0 && ndig_q <= 4'd8) addr_d = acc_q[ADDR_W-1:0];
              else                                  err_inc = 1'b1;
              state_d = back_st;
            end
            default: state_d = back_st;
          endcase
        end else if (state_q != ST_SKIP) begin
          if (is_hex) begin
            acc_d = {acc_q[27:0], nibble};
            if (ndig_q != 4'd9) ndig_d = ndig_q + 4'd1;
          end else if (is_at && ndig_q == 4'd0) begin
            state_d = ST_ADDR;
          end else begin
            err_inc = 1'b1;
            state_d = ST_SKIP;
            acc_d   = 32'd0;
            ndig_d  = 4'd0;
          end
        end
      end else if (have_word) begin
        // Terminal count on the idle down-counter; any partial token is dropped.
        if (tmr_q == TMR_W'(1)) begin
          state_d = ST_DONE;
          acc_d   = 32'd0;
          ndig_d  = 4'd0;
        end
        if (tmr_q != '0) tmr_d = tmr_q - TMR_W'(1);
      end
    end

    if (wr) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = addr_q;
      mem_wdata_d = acc_q;
      addr_d      = addr_q + 1'b1;
      state_d     = ST_DATA;
      if (word_cnt_q != 16'hFFFF) word_cnt_d = word_cnt_q + 16'd1;
    end
    if (err_inc && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ST_WAIT;
      addr_q      <= '0;
      acc_q       <= 32'd0;
      ndig_q      <= 4'd0;
      word_cnt_q  <= 16'd0;
      err_cnt_q   <= 8'd0;
      tmr_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      acc_q       <= acc_d;
      ndig_q      <= ndig_d;
      word_cnt_q  <= word_cnt_d;
      err_cnt_q   <= err_cnt_d;
      tmr_q       <= tmr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= (state_q != ST_DONE);
      load_done_q <= (state_q == ST_DONE);
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign load_done     = load_done_q;
  assign word_cnt      = word_cnt_q;
  assign err_cnt       = err_cnt_q;

`ifdef LOADER_ECHO_EN
  logic [7:0] tx_data_q;
  logic       tx_valid_q, echo_ovf_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      echo_ovf_q <= 1'b0;
    end else begin
      tx_valid_q <= bus.rx_valid & bus.tx_ready;
      if (bus.rx_valid & bus.tx_ready)  tx_data_q  <= bus.rx_data;
      if (bus.rx_valid & ~bus.tx_ready) echo_ovf_q <= 1'b1;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign echo_ovf     = echo_ovf_q;
`else
  logic unused_tx_ready;
  assign unused_tx_ready = bus.tx_ready;
  assign bus.tx_data     = 8'd0;
  assign bus.tx_valid    = 1'b0;
  assign echo_ovf        = 1'b0;
`endif
endmodule
